// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-side bus: hazard/EX inputs to the PC controller and its fetch/flush outputs.
interface fetch_pc_ctrl_if #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
);
    logic             stall_i;
    logic             pc_sel_i;
    logic [31:0]      br_pc_i;
    logic [PC_W-1:0]  pc_o;
    logic [31:0]      pc_four_o;
    logic             fetch_valid_o;
    logic             flush_o;
    logic [CNT_W-1:0] redirect_cnt_o;
    logic             fault_o;

    modport master (
        output stall_i, pc_sel_i, br_pc_i,
        input  pc_o, pc_four_o, fetch_valid_o, flush_o, redirect_cnt_o, fault_o
    );
    modport slave (
        input  stall_i, pc_sel_i, br_pc_i,
        output pc_o, pc_four_o, fetch_valid_o, flush_o, redirect_cnt_o, fault_o
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register with stall/redirect handling, pipeline flush and redirect counter.
// Optional REDIRECT_ALIGN_CHK_EN traps misaligned redirect targets into a sticky HALT.
module fetch_pc_ctrl #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input logic            clk,
    input logic            rst_n,
    fetch_pc_ctrl_if.slave bus
);
`ifdef REDIRECT_ALIGN_CHK_EN
    typedef enum logic [1:0] {BOOT, RUN, SQUASH, HALT} state_e;
`else
    typedef enum logic [1:0] {BOOT, RUN, SQUASH} state_e;
`endif

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    state_e           state_q;
    logic [PC_W-1:0]  pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             vld_q;
    logic             fault_q;
    logic             unused_br_hi;

    // Upper target bits are intentionally dropped.
    assign unused_br_hi = ^bus.br_pc_i[31:PC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    vld_q   <= 1'b1;
                end
                RUN: begin
                    if (bus.pc_sel_i) begin
`ifdef REDIRECT_ALIGN_CHK_EN
                        if (bus.br_pc_i[1:0] != 2'b00) begin
                            state_q <= HALT;
                            vld_q   <= 1'b0;
                            fault_q <= 1'b1;
                        end else begin
                            pc_q    <= bus.br_pc_i[PC_W-1:0];
                            state_q <= SQUASH;
                            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                        end
`else
                        pc_q    <= bus.br_pc_i[PC_W-1:0];
                        state_q <= SQUASH;
                        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
`endif
                    end else if (!bus.stall_i) begin
                        pc_q <= pc_q + PC_STEP;
                    end
                end
                SQUASH: begin
                    // EX holds the flushed bubble, so a redirect request here is bogus.
                    state_q <= RUN;
                    if (!bus.stall_i) pc_q <= pc_q + PC_STEP;
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign bus.pc_o           = pc_q;
    assign bus.pc_four_o      = 32'(pc_q) + 32'd4;
    assign bus.fetch_valid_o  = vld_q;
    assign bus.flush_o        = (state_q == RUN) && bus.pc_sel_i;
    assign bus.redirect_cnt_o = cnt_q;
`ifdef REDIRECT_ALIGN_CHK_EN
    assign bus.fault_o        = fault_q;
`else
    assign bus.fault_o        = 1'b0;
    logic unused_fault;
    assign unused_fault = fault_q;
`endif
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl; a second narrow-counter instance covers saturation.
module tb_fetch_pc_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl_if #(.PC_W(9), .CNT_W(16)) ifm ();
    fetch_pc_ctrl_if #(.PC_W(9), .CNT_W(2))  ifs ();

    assign ifs.stall_i  = ifm.stall_i;
    assign ifs.pc_sel_i = ifm.pc_sel_i;
    assign ifs.br_pc_i  = ifm.br_pc_i;

    fetch_pc_ctrl #(.PC_W(9), .RESET_PC(9'h000), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifm.slave)
    );
    fetch_pc_ctrl #(.PC_W(9), .RESET_PC(9'h000), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(ifs.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifm.stall_i  = 1'b0;
        ifm.pc_sel_i = 1'b0;
        ifm.br_pc_i  = 32'h0;

        // Reset state
        #12;
        chk("rst_pc", 32'(ifm.pc_o), 32'h000);
        chk("rst_fv", 32'(ifm.fetch_valid_o), 32'h0);
        chk("rst_flush", 32'(ifm.flush_o), 32'h0);
        chk("rst_cnt", 32'(ifm.redirect_cnt_o), 32'h0);
        chk("rst_fault", 32'(ifm.fault_o), 32'h0);

        // BOOT cycle then sequential fetch
        #1 rst_n = 1'b1;
        #1 chk("boot_fv", 32'(ifm.fetch_valid_o), 32'h0);
        tick();
        chk("run_pc0", 32'(ifm.pc_o), 32'h000);
        chk("run_fv", 32'(ifm.fetch_valid_o), 32'h1);
        chk("pc_four0", ifm.pc_four_o, 32'h004);
        tick();
        chk("run_pc4", 32'(ifm.pc_o), 32'h004);
        tick();
        chk("run_pc8", 32'(ifm.pc_o), 32'h008);

        // Two-cycle stall
        ifm.stall_i = 1'b1;
        tick();
        chk("stall1_pc", 32'(ifm.pc_o), 32'h008);
        chk("stall1_flush", 32'(ifm.flush_o), 32'h0);
        tick();
        chk("stall2_pc", 32'(ifm.pc_o), 32'h008);
        ifm.stall_i = 1'b0;
        tick();
        chk("unstall_pc", 32'(ifm.pc_o), 32'h00C);
        tick();
        chk("pc10", 32'(ifm.pc_o), 32'h010);

        // Taken redirect to 0x40
        ifm.pc_sel_i = 1'b1;
        ifm.br_pc_i  = 32'h40;
        #1 chk("redir_flush", 32'(ifm.flush_o), 32'h1);
        tick();
        ifm.pc_sel_i = 1'b0;
        #1;
        chk("squash_pc", 32'(ifm.pc_o), 32'h040);
        chk("squash_fv", 32'(ifm.fetch_valid_o), 32'h1);
        chk("squash_flush", 32'(ifm.flush_o), 32'h0);
        chk("cnt1", 32'(ifm.redirect_cnt_o), 32'h1);
        tick();
        chk("post_squash_pc", 32'(ifm.pc_o), 32'h044);

        // Redirect beats stall; redirect in SQUASH ignored
        ifm.stall_i  = 1'b1;
        ifm.pc_sel_i = 1'b1;
        ifm.br_pc_i  = 32'h80;
        #1 chk("stall_redir_flush", 32'(ifm.flush_o), 32'h1);
        tick();
        chk("stall_redir_pc", 32'(ifm.pc_o), 32'h080);
        chk("cnt2", 32'(ifm.redirect_cnt_o), 32'h2);
        ifm.stall_i = 1'b0;
        ifm.br_pc_i = 32'h100;
        #1 chk("squash_sel_flush", 32'(ifm.flush_o), 32'h0);
        tick();
        chk("squash_sel_pc", 32'(ifm.pc_o), 32'h084);
        chk("squash_sel_cnt", 32'(ifm.redirect_cnt_o), 32'h2);

        // Wrap at top of address space
        ifm.br_pc_i = 32'h1F8;
        tick();
        ifm.pc_sel_i = 1'b0;
        #1 chk("cnt3", 32'(ifm.redirect_cnt_o), 32'h3);
        tick();
        chk("pc_1fc", 32'(ifm.pc_o), 32'h1FC);
        chk("pc_four_1fc", ifm.pc_four_o, 32'h200);
        tick();
        chk("wrap_pc", 32'(ifm.pc_o), 32'h000);

        // Upper target bits dropped; narrow counter saturates at 3
        ifm.pc_sel_i = 1'b1;
        ifm.br_pc_i  = 32'hFFFF_FE20;
        tick();
        ifm.pc_sel_i = 1'b0;
        #1;
        chk("trunc_pc", 32'(ifm.pc_o), 32'h020);
        chk("cnt4", 32'(ifm.redirect_cnt_o), 32'h4);
        chk("sat_cnt", 32'(ifs.redirect_cnt_o), 32'h3);
        tick();
        chk("pc24", 32'(ifm.pc_o), 32'h024);

        // Misaligned target
        ifm.pc_sel_i = 1'b1;
        ifm.br_pc_i  = 32'h42;
        #1 chk("mis_flush", 32'(ifm.flush_o), 32'h1);
        tick();
`ifdef REDIRECT_ALIGN_CHK_EN
        chk("mis_pc_held", 32'(ifm.pc_o), 32'h024);
        chk("mis_fault", 32'(ifm.fault_o), 32'h1);
        chk("mis_fv", 32'(ifm.fetch_valid_o), 32'h0);
        chk("mis_cnt", 32'(ifm.redirect_cnt_o), 32'h4);
        ifm.stall_i = 1'b0;
        tick();
        tick();
        chk("halt_pc", 32'(ifm.pc_o), 32'h024);
        chk("halt_fault", 32'(ifm.fault_o), 32'h1);
        chk("halt_fv", 32'(ifm.fetch_valid_o), 32'h0);
        chk("halt_flush", 32'(ifm.flush_o), 32'h0);
        ifm.pc_sel_i = 1'b0;
`else
        ifm.pc_sel_i = 1'b0;
        #1;
        chk("mis_pc", 32'(ifm.pc_o), 32'h042);
        chk("mis_fault", 32'(ifm.fault_o), 32'h0);
        chk("mis_cnt", 32'(ifm.redirect_cnt_o), 32'h5);
`endif

        // Reset pulse mid-operation
        rst_n = 1'b0;
        #2;
        chk("midrst_pc", 32'(ifm.pc_o), 32'h000);
        chk("midrst_fv", 32'(ifm.fetch_valid_o), 32'h0);
        chk("midrst_cnt", 32'(ifm.redirect_cnt_o), 32'h0);
        chk("midrst_fault", 32'(ifm.fault_o), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("reboot_pc", 32'(ifm.pc_o), 32'h000);
        chk("reboot_fv", 32'(ifm.fetch_valid_o), 32'h1);
        tick();
        chk("reboot_pc4", 32'(ifm.pc_o), 32'h004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
